// File: rtl/eth_pkt_if_field_extract_if.sv
// Packet interface properties and the packet stream interface.
package eth_pkt_lib;

  typedef struct packed {
    logic [15:0] data_width;
    logic [15:0] tuser_width;
    logic [15:0] mod_width;
  } if_properties_t;

  localparam if_properties_t DEFAULT_PROPERTIES = '{
    data_width:  16'd64,
    tuser_width: 16'd8,
    mod_width:   16'd3
  };

  function automatic int get_if_data_width(input if_properties_t p);
    return int'(p.data_width);
  endfunction

  function automatic int get_if_tuser_width(input if_properties_t p);
    return int'(p.tuser_width);
  endfunction

  function automatic int get_if_mod_width(input if_properties_t p);
    return int'(p.mod_width);
  endfunction

endpackage

// Streaming packet interface: one word per val&ready transfer.
interface eth_pkt_if #(
  parameter eth_pkt_lib::if_properties_t PROPS = eth_pkt_lib::DEFAULT_PROPERTIES
);
  localparam int DW = eth_pkt_lib::get_if_data_width(PROPS);
  localparam int TW = eth_pkt_lib::get_if_tuser_width(PROPS);
  localparam int MW = eth_pkt_lib::get_if_mod_width(PROPS);

  logic [DW-1:0] data;
  logic [TW-1:0] tuser;
  logic          sop;
  logic          eop;
  logic [MW-1:0] mod;
  logic          val;
  logic          ready;

  modport i (input data, tuser, sop, eop, mod, val, output ready);
  modport o (output data, tuser, sop, eop, mod, val, input ready);
endinterface

// File: rtl/eth_pkt_if_field_extract.sv
// In-line field reader: passes the packet stream through untouched and
// captures a fixed window of words (plus the sop tuser) from each packet
// into a one-entry result register offered over valid/ready.
module eth_pkt_if_field_extract
  import eth_pkt_lib::*;
#(
  parameter if_properties_t IF_PROPERTIES = DEFAULT_PROPERTIES,
  parameter int FIELD_OFFSET = 1,
  parameter int FIELD_WORDS  = 2,
  parameter int CNT_WIDTH    = 16,
  localparam int D_WIDTH     = get_if_data_width(IF_PROPERTIES),
  localparam int TUSER_WIDTH = get_if_tuser_width(IF_PROPERTIES)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  eth_pkt_if.i                           pkt_i,
  eth_pkt_if.o                           pkt_o,
  output logic [FIELD_WORDS*D_WIDTH-1:0] field_o,
  output logic [TUSER_WIDTH-1:0]         field_tuser_o,
  output logic                           field_val_o,
  input  logic                           field_ready_i,
  output logic                           field_trunc_o,
  output logic                           field_ovf_o,
  output logic                           sop_err_o
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;

  localparam logic [CNT_WIDTH-1:0] WIN_FIRST = CNT_WIDTH'(FIELD_OFFSET);
  localparam logic [CNT_WIDTH-1:0] WIN_LAST  = CNT_WIDTH'(FIELD_OFFSET + FIELD_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_e                                  state_q, state_d;
  logic [CNT_WIDTH-1:0]                    cnt_q, cnt_d;
  logic [FIELD_WORDS-1:0][D_WIDTH-1:0]     stage_q, stage_d;
  logic [TUSER_WIDTH-1:0]                  stage_tuser_q, stage_tuser_d;
  logic [FIELD_WORDS*D_WIDTH-1:0]          field_q, field_d;
  logic [TUSER_WIDTH-1:0]                  field_tuser_q, field_tuser_d;
  logic                                    field_val_q, field_val_d;
  logic                                    trunc_q, trunc_d;
  logic                                    ovf_q, ovf_d;
  logic                                    sop_err_q, sop_err_d;
  logic                                    commit;
  logic                                    xfer;

  // Stream path is a straight wire; this block never stalls it.
  assign pkt_o.data  = pkt_i.data;
  assign pkt_o.tuser = pkt_i.tuser;
  assign pkt_o.sop   = pkt_i.sop;
  assign pkt_o.eop   = pkt_i.eop;
  assign pkt_o.mod   = pkt_i.mod;
  assign pkt_o.val   = pkt_i.val;
  assign pkt_i.ready = pkt_o.ready;

  assign xfer = pkt_i.val & pkt_o.ready;

  // Next-state: window capture FSM, commit into the result register, handshake.
  always_comb begin
    // NOTE: every signal gets its default first so no path through the
    // branches below leaves a variable unassigned (which would infer a latch).
    state_d       = state_q;
    cnt_d         = cnt_q;
    stage_d       = stage_q;
    stage_tuser_d = stage_tuser_q;
    field_d       = field_q;
    field_tuser_d = field_tuser_q;
    field_val_d   = field_val_q;
    trunc_d       = 1'b0;
    ovf_d         = 1'b0;
    sop_err_d     = 1'b0;
    commit        = 1'b0;

    if (xfer) begin
      if (pkt_i.sop) begin
        // A sop always (re)starts capture; inside a packet it is flagged and
        // the unfinished packet is dropped silently.
        sop_err_d     = (state_q != IDLE);
        stage_tuser_d = pkt_i.tuser;
        cnt_d         = CNT_ONE;
        if (FIELD_OFFSET == 0) stage_d[0] = pkt_i.data;
        if (FIELD_OFFSET == 0 && FIELD_WORDS == 1) begin
          commit  = 1'b1;
          state_d = pkt_i.eop ? IDLE : DONE;
        end else if (pkt_i.eop) begin
          trunc_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end else begin
        case (state_q)
          CAPTURE: begin
            for (int i = 0; i < FIELD_WORDS; i++) begin
              if (cnt_q == WIN_FIRST + CNT_WIDTH'(i)) stage_d[i] = pkt_i.data;
            end
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == WIN_LAST) begin
              commit  = 1'b1;
              state_d = pkt_i.eop ? IDLE : DONE;
            end else if (pkt_i.eop) begin
              trunc_d = 1'b1;
              state_d = IDLE;
            end
          end
          DONE: begin
            if (pkt_i.eop) state_d = IDLE;
          end
          default: ;
        endcase
      end
    end

    // Word FIELD_OFFSET lands in the MSBs of field_o.
    if (commit) begin
      if (!field_val_q || field_ready_i) begin
        for (int i = 0; i < FIELD_WORDS; i++) begin
          field_d[(FIELD_WORDS-1-i)*D_WIDTH +: D_WIDTH] = stage_d[i];
        end
        field_tuser_d = stage_tuser_d;
        field_val_d   = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (field_val_q && field_ready_i) begin
      field_val_d = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      // NOTE: the staging words are cleared too; they are few, and a known
      // reset value keeps every output and internal node deterministic.
      stage_q       <= '0;
      stage_tuser_q <= '0;
      field_q       <= '0;
      field_tuser_q <= '0;
      field_val_q   <= 1'b0;
      trunc_q       <= 1'b0;
      ovf_q         <= 1'b0;
      sop_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values, independent of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_q       <= stage_d;
      stage_tuser_q <= stage_tuser_d;
      field_q       <= field_d;
      field_tuser_q <= field_tuser_d;
      field_val_q   <= field_val_d;
      trunc_q       <= trunc_d;
      ovf_q         <= ovf_d;
      sop_err_q     <= sop_err_d;
    end
  end

  assign field_o       = field_q;
  assign field_tuser_o = field_tuser_q;
  assign field_val_o   = field_val_q;
  assign field_trunc_o = trunc_q;
  assign field_ovf_o   = ovf_q;
  assign sop_err_o     = sop_err_q;

endmodule

// File: tb/tb_eth_pkt_if_field_extract.sv
// Self-checking bench for eth_pkt_if_field_extract with a packet-level
// reference model (word index within packet, list of captured words).
module tb_eth_pkt_if_field_extract;

  localparam int DW  = 64;
  localparam int TW  = 8;
  localparam int MW  = 3;
  localparam int OFF = 1;
  localparam int W   = 2;
  localparam int VW  = 4 + W*DW + TW;
  localparam int PW  = DW + TW + MW + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              field_ready;
  logic [W*DW-1:0]   field;
  logic [TW-1:0]     field_tuser;
  logic              field_val, trunc, ovf, sop_err;

  eth_pkt_if pkt_in ();
  eth_pkt_if pkt_out ();

  eth_pkt_if_field_extract #(.FIELD_OFFSET(OFF), .FIELD_WORDS(W)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pkt_i         (pkt_in),
    .pkt_o         (pkt_out),
    .field_o       (field),
    .field_tuser_o (field_tuser),
    .field_val_o   (field_val),
    .field_ready_i (field_ready),
    .field_trunc_o (trunc),
    .field_ovf_o   (ovf),
    .sop_err_o     (sop_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: packet-level view.
  bit              m_inpkt, m_open;
  int              m_idx;
  logic [DW-1:0]   m_words[$];
  logic [TW-1:0]   m_tuser;
  logic [W*DW-1:0] exp_field;
  logic [TW-1:0]   exp_tuser;
  bit              exp_val, exp_trunc, exp_ovf, exp_sop_err;

  logic [PW-1:0]   pt_obs, pt_exp;

  function automatic logic [VW-1:0] obs_vec();
    return {field_val, trunc, ovf, sop_err, field, field_tuser};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_val, exp_trunc, exp_ovf, exp_sop_err, exp_field, exp_tuser};
  endfunction

  task automatic model_reset();
    m_inpkt = 0; m_open = 0; m_idx = 0; m_words.delete(); m_tuser = '0;
    exp_field = '0; exp_tuser = '0;
    exp_val = 0; exp_trunc = 0; exp_ovf = 0; exp_sop_err = 0;
  endtask

  // Drive one cycle of stimulus and advance the model across the clock edge.
  task automatic step(input bit v, input bit s, input bit e, input logic [DW-1:0] d,
                      input logic [TW-1:0] tu, input logic [MW-1:0] md,
                      input bit rdy, input bit frdy);
    bit xfer, done, complete;
    @(negedge clk);
    pkt_in.val = v; pkt_in.sop = s; pkt_in.eop = e; pkt_in.data = d;
    pkt_in.tuser = tu; pkt_in.mod = md; pkt_out.ready = rdy; field_ready = frdy;
    #1;
    pt_obs = {pkt_out.data, pkt_out.tuser, pkt_out.sop, pkt_out.eop, pkt_out.mod,
              pkt_out.val, pkt_in.ready};
    pt_exp = {d, tu, s, e, md, v, rdy};
    xfer = v && rdy;
    done = exp_val && frdy;
    complete = 0;
    exp_trunc = 0; exp_ovf = 0; exp_sop_err = 0;
    if (xfer) begin
      if (s) begin
        if (m_inpkt) exp_sop_err = 1;
        m_inpkt = 1; m_open = 1; m_idx = 0; m_words.delete(); m_tuser = tu;
      end else if (m_inpkt) begin
        m_idx++;
      end
      if (m_inpkt) begin
        if (m_open && m_idx >= OFF && m_idx < OFF + W) begin
          m_words.push_back(d);
          if (m_words.size() == W) begin complete = 1; m_open = 0; end
        end
        if (e) begin
          if (m_open) exp_trunc = 1;
          m_inpkt = 0; m_open = 0;
        end
      end
    end
    if (complete) begin
      if (!exp_val || frdy) begin
        for (int i = 0; i < W; i++) exp_field[(W-1-i)*DW +: DW] = m_words[i];
        exp_tuser = m_tuser;
        exp_val = 1;
      end else begin
        exp_ovf = 1;
      end
    end else if (done) begin
      exp_val = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit frdy);
    step(0, 0, 0, '0, '0, '0, 1, frdy);
  endtask

  task automatic test_reset();
    rst_n = 0;
    pkt_in.val = 0; pkt_in.sop = 0; pkt_in.eop = 0; pkt_in.data = '0;
    pkt_in.tuser = '0; pkt_in.mod = '0; pkt_out.ready = 1; field_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", obs_vec());
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_default();
    for (int i = 0; i < 5; i++) begin
      step(1, i == 0, i == 4, DW'(i), (i == 0) ? 8'h05 : 8'hA0 | 8'(i), 3'(i), 1, 1);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL default_w%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (pt_obs !== pt_exp) begin
        miscompares++;
        $display("FAIL default_pass_w%0d: got %h want %h", i, pt_obs, pt_exp);
      end
      if (i == 2) begin
        vectors++;
        if (field !== {64'd1, 64'd2} || field_tuser !== 8'h05 || field_val !== 1'b1) begin
          miscompares++;
          $display("FAIL default_field: got %h/%h/%b want %h/05/1", field, field_tuser,
                   field_val, {64'd1, 64'd2});
        end
      end
      if (i == 3) begin
        vectors++;
        if (field_val !== 1'b0) begin
          miscompares++;
          $display("FAIL default_val_len: got %b want 0", field_val);
        end
      end
    end
  endtask

  task automatic test_trunc();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) step(1, i == 0, i == 1, 64'h30 + DW'(i), 8'h33, '0, 1, 1);
      else idle(1);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL trunc_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (trunc !== (i == 1) || field_val !== 1'b0) begin
        miscompares++;
        $display("FAIL trunc_pulse_c%0d: got trunc=%b val=%b want trunc=%b val=0",
                 i, trunc, field_val, i == 1);
      end
    end
  endtask

  task automatic test_back_to_back_ovf();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        step(1, i == 0, i == 3, 64'h100 * DW'(p + 1) + DW'(i), 8'(p + 1), '0, 1, 0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL ovf_p%0d_w%0d: got %h want %h", p, i, obs_vec(), exp_vec());
        end
        if (p == 1 && i == 2) begin
          vectors++;
          if (ovf !== 1'b1 || field !== {64'h101, 64'h102} || field_tuser !== 8'h01 ||
              field_val !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_hold: got ovf=%b field=%h tuser=%h val=%b want 1/%h/01/1",
                     ovf, field, field_tuser, field_val, {64'h101, 64'h102});
          end
        end
      end
    end
    idle(1);
    vectors++;
    if (obs_vec() !== exp_vec() || field_val !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_drain: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) begin
      step(1, (i / 2) == 0, (i / 2) == 3, 64'h500 + DW'(i / 2), 8'h44, '0, (i % 2) == 0, 1);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (field !== {64'h501, 64'h502} || field_tuser !== 8'h44) begin
      miscompares++;
      $display("FAIL stall_field: got %h/%h want %h/44", field, field_tuser,
               {64'h501, 64'h502});
    end
  endtask

  task automatic test_sop_err();
    logic [DW-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = (i < 2) ? 64'h600 + DW'(i) : 64'h700 + DW'(i - 2);
      step(1, i == 0 || i == 2, i == 5, d, (i < 2) ? 8'h66 : 8'h77, '0, 1, 1);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL soperr_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (sop_err !== (i == 2) || trunc !== 1'b0) begin
        miscompares++;
        $display("FAIL soperr_pulse_c%0d: got sop_err=%b trunc=%b want %b/0",
                 i, sop_err, trunc, i == 2);
      end
      if (i == 4) begin
        vectors++;
        if (field !== {64'h701, 64'h702} || field_tuser !== 8'h77) begin
          miscompares++;
          $display("FAIL soperr_field: got %h/%h want %h/77", field, field_tuser,
                   {64'h701, 64'h702});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 0, 64'h800, 8'h88, '0, 1, 1);
    step(1, 0, 0, 64'h801, 8'h88, '0, 1, 1);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    vectors++;
    if (obs_vec() !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: got %h want 0", obs_vec());
    end
    vectors++;
    if (pkt_out.data !== pkt_in.data || pkt_out.val !== pkt_in.val) begin
      miscompares++;
      $display("FAIL rstmid_pass: got %h want %h", pkt_out.data, pkt_in.data);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obs_vec() !== '0) begin
      miscompares++;
      $display("FAIL rstmid_hold: got %h want 0", obs_vec());
    end
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 1, 64'h802, 8'h88, '0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, i == 0, i == 3, 64'h900 + DW'(i), 8'h99, '0, 1, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rstmid_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (field !== {64'h901, 64'h902} || field_tuser !== 8'h99 || field_val !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_field: got %h/%h/%b want %h/99/1", field, field_tuser,
               field_val, {64'h901, 64'h902});
    end
    idle(1);
  endtask

  task automatic test_random();
    bit v, s, e, rdy, frdy;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom % 4) != 0;
      s    = ($urandom % 5) == 0;
      e    = ($urandom % 4) == 0;
      rdy  = ($urandom % 4) != 0;
      frdy = ($urandom % 3) != 0;
      step(v, s, e, {$urandom, $urandom}, 8'($urandom), 3'($urandom), rdy, frdy);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (pt_obs !== pt_exp) begin
        miscompares++;
        $display("FAIL random_pass_c%0d: got %h want %h", i, pt_obs, pt_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_trunc();
    test_back_to_back_ovf();
    test_stall();
    test_sop_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
